// File: rtl/hybrid_branch_predictor.sv
// ============================================================================
// hybrid_branch_predictor
// ----------------------------------------------------------------------------
// Tournament branch predictor for the Chronos fetch stage. A bimodal table,
// a gshare table and a per-entry chooser are placed behind a direct-mapped
// BTB. Lookup is combinational from pred_pc. One resolved-branch update is
// accepted per cycle. A speculative global history register (GHR) is kept
// and is repaired on mispredict.
//
// Parameters
//   INDEX_BITS : log2 entries of the bimodal/gshare/chooser/BTB tables
//   GHR_BITS   : global history length (1..INDEX_BITS)
//   CTR_BITS   : saturating counter width for all counter tables
//   TAG_BITS   : BTB tag width
//
// Ports
//   clk             : clock, rising edge
//   rst             : asynchronous active-low reset
//   pred_valid      : fetch consumes the prediction this cycle
//   pred_pc         : fetch address
//   pred_hit        : BTB valid and tag match
//   pred_taken      : predicted taken
//   pred_target     : next fetch address
//   pred_ghr        : history used for this lookup (carried to EX)
//   upd_valid       : resolved branch presented
//   upd_pc          : PC of the resolved branch
//   upd_ghr         : pred_ghr captured when the branch was predicted
//   upd_taken       : actual direction
//   upd_target      : actual taken target
//   upd_mispredict  : direction or target was wrong (qualified by upd_valid)
//
// Optional feature (macro HBP_PERF_COUNTERS_EN)
//   perf_lookups     : count of cycles with pred_valid high
//   perf_mispredicts : count of cycles with upd_valid and upd_mispredict high
// ============================================================================
module hybrid_branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int GHR_BITS   = 6,
    parameter int CTR_BITS   = 2,
    parameter int TAG_BITS   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    input  logic                upd_mispredict
`ifdef HBP_PERF_COUNTERS_EN
    ,
    output logic [31:0]         perf_lookups,
    output logic [31:0]         perf_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // Weakly not-taken / weakly bimodal: the value just below the MSB flip.
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------

    // Table index from a word-aligned PC.
    function automatic logic [INDEX_BITS-1:0] pc_idx(input logic [31:0] pc);
        return pc[INDEX_BITS+1:2];
    endfunction

    // BTB tag: the PC bits directly above the index.
    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [31:0] pc);
        return pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    endfunction

    // History is zero-extended to the index width before the XOR.
    function automatic logic [INDEX_BITS-1:0] hist_ext(input logic [GHR_BITS-1:0] h);
        return INDEX_BITS'(h);
    endfunction

    // Shift one outcome into the history; the oldest bit falls off the top.
    // Written as a truncating cast so GHR_BITS=1 needs no special case.
    function automatic logic [GHR_BITS-1:0] hist_shift(input logic [GHR_BITS-1:0] h,
                                                       input logic              b);
        return GHR_BITS'({h, b});
    endfunction

    // Saturating up/down counter step.
    function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] ctr,
                                                     input logic                up);
        logic [CTR_BITS-1:0] res;
        res = ctr;
        if (up) begin
            if (ctr != CTR_MAX) begin
                res = ctr + CTR_ONE;
            end else begin
                res = ctr;
            end
        end else begin
            if (ctr != CTR_MIN) begin
                res = ctr - CTR_ONE;
            end else begin
                res = ctr;
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CTR_BITS-1:0]   bim_r        [ENTRIES];
    logic [CTR_BITS-1:0]   gsh_r        [ENTRIES];
    logic [CTR_BITS-1:0]   cho_r        [ENTRIES];
    logic                  btb_valid_r  [ENTRIES];
    logic [TAG_BITS-1:0]   btb_tag_r    [ENTRIES];
    logic [31:0]           btb_target_r [ENTRIES];
    logic [GHR_BITS-1:0]   ghr_r;

    // Lookup path
    logic [INDEX_BITS-1:0] p_idx_s;
    logic [INDEX_BITS-1:0] p_gidx_s;
    logic [TAG_BITS-1:0]   p_tag_s;
    logic [CTR_BITS-1:0]   p_sel_ctr_s;
    logic                  p_hit_s;
    logic                  p_taken_s;
    logic [31:0]           p_target_s;

    // Update path
    logic [INDEX_BITS-1:0] u_idx_s;
    logic [INDEX_BITS-1:0] u_gidx_s;
    logic [TAG_BITS-1:0]   u_tag_s;
    logic                  u_bim_msb_s;
    logic                  u_gsh_msb_s;
    logic                  u_cho_en_s;
    logic                  u_cho_up_s;
    logic                  u_repair_s;

    // Only the index/tag slices of upd_pc steer the tables; the rest is
    // folded here so the unused bits are visibly accounted for.
    logic                  upd_pc_unused_s;
    assign upd_pc_unused_s = ^upd_pc;

    // ------------------------------------------------------------------------
    // Lookup (combinational, sees pre-update contents; no bypass)
    // ------------------------------------------------------------------------

    // Select bimodal or gshare counter via chooser MSB and form the target.
    always_comb begin
        p_idx_s  = pc_idx(pred_pc);
        p_tag_s  = pc_tag(pred_pc);
        p_gidx_s = p_idx_s ^ hist_ext(ghr_r);
        p_hit_s  = btb_valid_r[p_idx_s] && (btb_tag_r[p_idx_s] == p_tag_s);
        if (cho_r[p_idx_s][CTR_BITS-1]) begin
            p_sel_ctr_s = gsh_r[p_gidx_s];
        end else begin
            p_sel_ctr_s = bim_r[p_idx_s];
        end
        p_taken_s = p_hit_s && p_sel_ctr_s[CTR_BITS-1];
        if (p_taken_s) begin
            p_target_s = btb_target_r[p_idx_s];
        end else begin
            p_target_s = pred_pc + 32'd4;
        end
    end

    assign pred_hit    = p_hit_s;
    assign pred_taken  = p_taken_s;
    assign pred_target = p_target_s;
    assign pred_ghr    = ghr_r;

    // ------------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------------

    // Update indices and chooser direction, read from the pre-update tables.
    always_comb begin
        u_idx_s     = pc_idx(upd_pc);
        u_tag_s     = pc_tag(upd_pc);
        u_gidx_s    = u_idx_s ^ hist_ext(upd_ghr);
        u_bim_msb_s = bim_r[u_idx_s][CTR_BITS-1];
        u_gsh_msb_s = gsh_r[u_gidx_s][CTR_BITS-1];
        // Components disagree => exactly one of them was right.
        u_cho_en_s  = u_bim_msb_s != u_gsh_msb_s;
        u_cho_up_s  = u_gsh_msb_s == upd_taken;
        u_repair_s  = upd_valid && upd_mispredict;
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------

    // Direction counters: both components train every update, chooser only
    // when the components disagreed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bim_r[i] <= CTR_INIT;
                gsh_r[i] <= CTR_INIT;
                cho_r[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            bim_r[u_idx_s]  <= ctr_step(bim_r[u_idx_s], upd_taken);
            gsh_r[u_gidx_s] <= ctr_step(gsh_r[u_gidx_s], upd_taken);
            if (u_cho_en_s) begin
                cho_r[u_idx_s] <= ctr_step(cho_r[u_idx_s], u_cho_up_s);
            end
        end
    end

    // BTB: taken outcomes allocate/overwrite; not-taken leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_r[i]  <= 1'b0;
                btb_tag_r[i]    <= {TAG_BITS{1'b0}};
                btb_target_r[i] <= 32'd0;
            end
        end else if (upd_valid && upd_taken) begin
            btb_valid_r[u_idx_s]  <= 1'b1;
            btb_tag_r[u_idx_s]    <= u_tag_s;
            btb_target_r[u_idx_s] <= upd_target;
        end
    end

    // GHR: repair from the resolved branch wins over the speculative shift;
    // a BTB miss never shifts history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_r <= {GHR_BITS{1'b0}};
        end else if (u_repair_s) begin
            ghr_r <= hist_shift(upd_ghr, upd_taken);
        end else if (pred_valid && p_hit_s) begin
            ghr_r <= hist_shift(ghr_r, p_taken_s);
        end
    end

`ifdef HBP_PERF_COUNTERS_EN
    logic [31:0] perf_lookups_r;
    logic [31:0] perf_mispredicts_r;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lookups_r     <= 32'd0;
            perf_mispredicts_r <= 32'd0;
        end else begin
            if (pred_valid) begin
                perf_lookups_r <= perf_lookups_r + 32'd1;
            end
            if (u_repair_s) begin
                perf_mispredicts_r <= perf_mispredicts_r + 32'd1;
            end
        end
    end

    assign perf_lookups     = perf_lookups_r;
    assign perf_mispredicts = perf_mispredicts_r;
`endif

endmodule

// File: tb/tb_hybrid_branch_predictor.sv
// ============================================================================
// tb_hybrid_branch_predictor
// ----------------------------------------------------------------------------
// Self-checking bench for hybrid_branch_predictor (default parameters).
// Directed table of vectors, hand-written history/reset sequences, a closed
// loop alternating branch, and randomized traffic checked against a
// behavioural model built from integer arrays.
// ============================================================================
module tb_hybrid_branch_predictor;

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [5:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_ghr;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
`ifdef HBP_PERF_COUNTERS_EN
    logic [31:0] perf_lookups;
    logic [31:0] perf_mispredicts;
`endif

    hybrid_branch_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_ghr        (upd_ghr),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict)
`ifdef HBP_PERF_COUNTERS_EN
        ,
        .perf_lookups     (perf_lookups),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_bim [64];
    int          m_gsh [64];
    int          m_cho [64];
    bit          m_val [64];
    int          m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ghr;
    int          m_lookups;
    int          m_misp;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_bim[i] = 1; m_gsh[i] = 1; m_cho[i] = 1;
            m_val[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'd0;
        end
        m_ghr = 0; m_lookups = 0; m_misp = 0;
    endfunction

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 3) ? 3 : v);
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic hit,
                                         output logic tk, output logic [31:0] tgt);
        int idx, tag, ctr;
        idx = int'((pc >> 2) % 32'd64);
        tag = int'((pc >> 8) % 32'd256);
        hit = m_val[idx] && (m_tag[idx] == tag);
        ctr = (m_cho[idx] >= 2) ? m_gsh[idx ^ m_ghr] : m_bim[idx];
        tk  = hit && (ctr >= 2);
        tgt = tk ? m_tgt[idx] : pc + 32'd4;
    endfunction

    function automatic void model_update(input logic pv, input logic uv, input logic [31:0] upc,
                                         input int ug, input logic ut, input logic [31:0] utg,
                                         input logic um, input logic p_hit, input logic p_tk);
        int idx, gidx, tag;
        bit bim_ok, gsh_ok;
        if (uv) begin
            idx    = int'((upc >> 2) % 32'd64);
            tag    = int'((upc >> 8) % 32'd256);
            gidx   = idx ^ ug;
            bim_ok = ((m_bim[idx] >= 2) == ut);
            gsh_ok = ((m_gsh[gidx] >= 2) == ut);
            if (bim_ok != gsh_ok) m_cho[idx] = sat(m_cho[idx] + (gsh_ok ? 1 : -1));
            m_bim[idx]  = sat(m_bim[idx] + (ut ? 1 : -1));
            m_gsh[gidx] = sat(m_gsh[gidx] + (ut ? 1 : -1));
            if (ut) begin
                m_val[idx] = 1'b1; m_tag[idx] = tag; m_tgt[idx] = utg;
            end
        end
        if (uv && um)         m_ghr = (ug * 2 + int'(ut)) % 64;
        else if (pv && p_hit) m_ghr = (m_ghr * 2 + int'(p_tk)) % 64;
        if (pv) m_lookups++;
        if (uv && um) m_misp++;
    endfunction

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic uv,
                         input logic [31:0] upc, input int ug, input logic ut,
                         input logic [31:0] utg, input logic um);
        pred_valid = pv; pred_pc = ppc; upd_valid = uv; upd_pc = upc;
        upd_ghr = 6'(ug); upd_taken = ut; upd_target = utg; upd_mispredict = um;
    endtask

    // One model-checked cycle; called right after a rising edge.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic uv,
                        input logic [31:0] upc, input int ug, input logic ut,
                        input logic [31:0] utg, input logic um, output logic dut_tk);
        logic e_hit, e_tk;
        logic [31:0] e_tgt;
        drive(pv, ppc, uv, upc, ug, ut, utg, um);
        @(negedge clk);
        model_lookup(ppc, e_hit, e_tk, e_tgt);
        check("model_hit", {31'd0, pred_hit}, {31'd0, e_hit});
        check("model_taken", {31'd0, pred_taken}, {31'd0, e_tk});
        check("model_target", pred_target, e_tgt);
        check("model_ghr", {26'd0, pred_ghr}, 32'(m_ghr));
        dut_tk = pred_taken;
        @(posedge clk);
        model_update(pv, uv, upc, ug, ut, utg, um, e_hit, e_tk);
        #1;
    endtask

    function automatic logic [31:0] rnd_pc();
        if ($urandom_range(0, 9) == 0) return 32'($urandom);
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        uv;
        logic [31:0] upc;
        int          ug;
        logic        ut;
        logic [31:0] utg;
        logic        um;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic [5:0]  e_ghr;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic pv, input logic [31:0] ppc, input logic uv,
                                input logic ut, input logic [31:0] utg,
                                input logic e_hit, input logic e_tk,
                                input logic [31:0] e_tgt, input logic [5:0] e_ghr);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.uv = uv; v.upc = 32'h100; v.ug = 0; v.ut = ut;
        v.utg = utg; v.um = 1'b0; v.e_hit = e_hit; v.e_tk = e_tk; v.e_tgt = e_tgt;
        v.e_ghr = e_ghr;
        return v;
    endfunction

    logic        dtk;
    int          alt_miss;
    logic        actual;
    logic        mh, mt;
    logic [31:0] mtg;

    initial begin
        // pv, ppc, uv, ut, utg | hit, taken, target, ghr (updates at 0x100, upd_ghr=0)
        vecs[0]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h104, 6'd0);
        vecs[1]  = mk(1'b0, 32'h100, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h104, 6'd0);
        vecs[2]  = mk(1'b0, 32'h100, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40,  6'd0);
        vecs[3]  = mk(1'b0, 32'h100, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h40,  6'd0);
        vecs[4]  = mk(1'b1, 32'h100, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h40,  6'd0);
        vecs[5]  = mk(1'b0, 32'h100, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h40,  6'd1);
        vecs[6]  = mk(1'b0, 32'h100, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h40,  6'd1);
        vecs[7]  = mk(1'b0, 32'h100, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h40,  6'd1);
        vecs[8]  = mk(1'b0, 32'h100, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40,  6'd1);
        vecs[9]  = mk(1'b0, 32'h100, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40,  6'd1);
        vecs[10] = mk(1'b0, 32'h100, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h104, 6'd1);
        vecs[11] = mk(1'b0, 32'h100, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h104, 6'd1);
        vecs[12] = mk(1'b0, 32'h300, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h304, 6'd1);
        vecs[13] = mk(1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd1);

        // ---- reset ----
        rst = 1'b0;
        drive(1'b1, 32'h100, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hit", {31'd0, pred_hit}, 32'd0);
        check("rst_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_target", pred_target, 32'h104);
        check("rst_ghr", {26'd0, pred_ghr}, 32'd0);
        pred_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ---- directed table: BTB train, saturation, misses, PC wrap ----
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].pv, vecs[i].ppc, vecs[i].uv, vecs[i].upc, vecs[i].ug,
                  vecs[i].ut, vecs[i].utg, vecs[i].um);
            @(negedge clk);
            check($sformatf("vec%0d_hit", i), {31'd0, pred_hit}, {31'd0, vecs[i].e_hit});
            check($sformatf("vec%0d_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_tk});
            check($sformatf("vec%0d_target", i), pred_target, vecs[i].e_tgt);
            check($sformatf("vec%0d_ghr", i), {26'd0, pred_ghr}, {26'd0, vecs[i].e_ghr});
            @(posedge clk);
            #1;
        end

        // ---- repair priority over a same-cycle speculative shift ----
        drive(1'b0, 32'h100, 1'b1, 32'h500, 6'b010101, 1'b0, 32'h0, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 32'h100, 1'b1, 32'h500, 6'b000111, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("repair_setup_ghr", {26'd0, pred_ghr}, 32'b101010);
        check("repair_hit", {31'd0, pred_hit}, 32'd1);
        @(posedge clk); #1;
        drive(1'b1, 32'h100, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("repair_prio_ghr", {26'd0, pred_ghr}, 32'b001110);
        @(posedge clk); #1;
        drive(1'b0, 32'h100, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("spec_shift_ghr", {26'd0, pred_ghr}, 32'b011100);
        @(posedge clk); #1;

        // ---- asynchronous reset between edges, cancelling an update ----
        drive(1'b0, 32'h100, 1'b1, 32'h600, 0, 1'b1, 32'h80, 1'b0);
        @(negedge clk);
        check("pre_areset_hit", {31'd0, pred_hit}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("areset_hit", {31'd0, pred_hit}, 32'd0);
        check("areset_taken", {31'd0, pred_taken}, 32'd0);
        check("areset_target", pred_target, 32'h104);
        check("areset_ghr", {26'd0, pred_ghr}, 32'd0);
`ifdef HBP_PERF_COUNTERS_EN
        check("areset_perf_lookups", perf_lookups, 32'd0);
        check("areset_perf_misp", perf_mispredicts, 32'd0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 32'h600, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        #1;
        check("areset_cancel_hit", {31'd0, pred_hit}, 32'd0);
        @(posedge clk); #1;
        model_reset();

        // ---- alternating branch at 0x200, resolved in the lookup cycle ----
        alt_miss = 0;
        for (int i = 0; i < 20; i++) begin
            actual = (i % 2 == 0);
            model_lookup(32'h200, mh, mt, mtg);
            step(1'b1, 32'h200, 1'b1, 32'h200, m_ghr, actual, 32'h300,
                 (mt != actual) || (actual && mtg != 32'h300), dtk);
            if (i >= 12 && dtk != actual) alt_miss++;
        end
        check("alt_last8_mispredicts", 32'(alt_miss), 32'd0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), rnd_pc(), ($urandom_range(0, 3) != 0), rnd_pc(),
                 ($urandom_range(0, 1) == 0) ? m_ghr : int'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), 32'($urandom),
                 ($urandom_range(0, 3) == 0), dtk);
        end
`ifdef HBP_PERF_COUNTERS_EN
        check("perf_lookups", perf_lookups, 32'(m_lookups));
        check("perf_mispredicts", perf_mispredicts, 32'(m_misp));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hybrid_branch_predictor.md
# hybrid_branch_predictor

Parametrised tournament branch predictor for the fetch stage of the Chronos pipeline. It combines a bimodal table, a gshare table and a per-entry chooser, fronted by a direct-mapped BTB. It returns a same-cycle direction and target for the fetch PC and accepts one resolved-branch update per cycle from EX. It keeps a speculative global history register (GHR) and repairs it on mispredict.

## Interface
- `INDEX_BITS`, default 6: log2 of entries in the bimodal, gshare, chooser and BTB tables (64 entries).
- `GHR_BITS`, default 6: global history length; legal range 1..INDEX_BITS.
- `CTR_BITS`, default 2: saturating counter width, used for all three counter tables.
- `TAG_BITS`, default 8: BTB tag width.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `pred_valid`, input, 1: fetch is consuming a prediction this cycle (low while stalled).
- `pred_pc`, input, 32: fetch address.
- `pred_hit`, output, 1: BTB tag match with the valid bit set.
- `pred_taken`, output, 1: predicted taken.
- `pred_target`, output, 32: next fetch address.
- `pred_ghr`, output, GHR_BITS: GHR value used for this lookup; the pipeline carries it to EX.
- `upd_valid`, input, 1: a resolved conditional branch or jump is presented.
- `upd_pc`, input, 32: PC of the resolved branch.
- `upd_ghr`, input, GHR_BITS: `pred_ghr` captured when that branch was predicted.
- `upd_taken`, input, 1: actual direction.
- `upd_target`, input, 32: actual taken target.
- `upd_mispredict`, input, 1: direction or target was wrong; qualified by `upd_valid`.

## Operation
- Indexing:
  - idx = pc[INDEX_BITS+1:2].
  - tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
  - gshare idx = idx XOR GHR, with GHR zero-extended to INDEX_BITS.
- Lookup is purely combinational from `pred_pc` and the current state:
  - `pred_hit` = BTB valid[idx] AND tag match.
  - The chooser MSB selects the source: 1 = gshare, 0 = bimodal.
  - `pred_taken` = `pred_hit` AND the MSB of the selected counter.
  - `pred_target` = the BTB target when `pred_taken`, otherwise `pred_pc`+4. The add wraps modulo 2^32.
  - `pred_ghr` = the current GHR.
- Speculative history: when `pred_valid` is high and `pred_hit` is high, GHR ← {GHR[GHR_BITS-2:0], `pred_taken`}. A BTB miss does not shift the GHR.
- Update, when `upd_valid` is high:
  - Bimodal[idx(upd_pc)] and gshare[idx(upd_pc) XOR `upd_ghr`] both count toward `upd_taken`. They saturate at 0 and at 2^CTR_BITS-1.
  - The chooser updates only when the bimodal and gshare MSBs, read at the update indices, disagree. It counts up if gshare was correct and down if bimodal was correct, and saturates.
  - If `upd_taken`, the BTB entry at idx gets valid=1, tag(upd_pc) and `upd_target`. This overwrites any previous entry.
  - If not taken, the BTB is untouched.
- Repair: when `upd_valid` and `upd_mispredict` are both high, GHR ← {`upd_ghr`[GHR_BITS-2:0], `upd_taken`}.
  - Repair has priority over a same-cycle speculative shift, which is discarded.
  - Outcomes the BTB never saw are not inserted into history beyond this rule.
- Update/lookup collision on the same entry in one cycle: the lookup sees the pre-update contents. There is no bypass.

## Timing
- Lookup latency is 0 cycles, combinational. The tables and GHR are flop arrays.
- Updates become visible to lookups on the cycle after the `upd_valid` edge.
- Reset (`rst` low), asynchronous and immediate:
  - Every bimodal and gshare counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for CTR_BITS=2).
  - Every chooser = 2^(CTR_BITS-1)-1 (weakly bimodal).
  - All BTB valid bits = 0; GHR = 0.
- Outputs during and after reset: `pred_hit`=0, `pred_taken`=0, `pred_target`=`pred_pc`+4, `pred_ghr`=0.
- Reset asserted mid-update cancels that update. Deassertion is synchronised externally.
- Throughput: one lookup and one update per cycle.

## Configuration
- `HBP_PERF_COUNTERS_EN` defined: adds two output ports, `perf_lookups` (32) and `perf_mispredicts` (32).
  - `perf_lookups` increments on each cycle with `pred_valid` high.
  - `perf_mispredicts` increments on each cycle with `upd_valid` and `upd_mispredict` both high.
  - Both wrap at 2^32 and reset to 0.
- `HBP_PERF_COUNTERS_EN` undefined: the ports and counters are absent. Prediction behaviour is identical.

## Test plan
- Reset: hold `rst`=0, then lookup with `pred_pc`=0x100 → `pred_hit`=0, `pred_taken`=0, `pred_target`=0x104, `pred_ghr`=0.
- BTB train: one update with `upd_pc`=0x100, `upd_taken`=1, `upd_target`=0x40, `upd_ghr`=0 → next-cycle lookup at 0x100 gives hit=1, taken=1 (bimodal 10), target=0x40.
- Saturation: five taken updates at 0x100, then three not-taken → bimodal path reads 11, 11, 11, 10, 01. The prediction flips to not-taken only after the second not-taken.
- Chooser: alternating taken/not-taken branch at 0x200 with correct `upd_ghr` for 20 updates → chooser reaches 11 and gshare predicts the alternation with 0 mispredicts over the last 8 lookups.
- Repair priority: with GHR=0b101010 and `pred_valid` plus a hit in the same cycle as a mispredict update (`upd_ghr`=0b000111, `upd_taken`=0) → GHR=0b001110 next cycle.
- Async reset mid-training: drop `rst` between clock edges → outputs return to reset values immediately. With the macro defined, both perf counters read 0.
